// File: rtl/ostimer_arbiter_pkg.sv
// ostimer_arb_pkg
// Shared constants and the FSM state encoding for the one-shot timer
// arbiter. Requester count and count width live here so that the
// interface and the top agree on every bus width.
package ostimer_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int VALUE_W = 32;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        TRIG = 2'd2,
        WAIT = 2'd3
    } state_t;

    // Round-robin successor of a requester index; wraps 3 -> 0.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/ostimer_arbiter_if.sv
// ostimer_arbiter_if
// Requester-side and timer-side signals of the one-shot timer arbiter.
//   req           per-requester single-cycle request strobe
//   req_value     per-requester count in ms, slice i = [i*VALUE_W +: VALUE_W]
//   req_ack       one-cycle pulse, request i accepted
//   done          one-cycle pulse, timer for requester i expired
//   busy          arbiter FSM not idle
//   grant_id      requester currently owning the timer
//   tmr_value     count driven to the timer (0 outside the load cycle)
//   tmr_set       timer load strobe
//   tmr_trigger   timer start strobe
//   tmr_interrupt one-cycle expiry pulse from the timer
// Modport slave is the arbiter side, master is the requester/timer side.
interface ostimer_arbiter_if;
    import ostimer_arb_pkg::*;

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*VALUE_W-1:0] req_value;
    logic [NUM_REQ-1:0]         req_ack;
    logic [NUM_REQ-1:0]         done;
    logic                       busy;
    logic [ID_W-1:0]            grant_id;
    logic [VALUE_W-1:0]         tmr_value;
    logic                       tmr_set;
    logic                       tmr_trigger;
    logic                       tmr_interrupt;

    modport slave (
        input  req, req_value, tmr_interrupt,
        output req_ack, done, busy, grant_id, tmr_value, tmr_set, tmr_trigger
    );

    modport master (
        output req, req_value, tmr_interrupt,
        input  req_ack, done, busy, grant_id, tmr_value, tmr_set, tmr_trigger
    );

endinterface

// File: rtl/ostimer_arbiter_rr.sv
// rr_arbiter4
// Combinational four-way round-robin pick. Searches the pending vector
// starting at rr_ptr and moving upward with wrap 3 -> 0.
//   pending  requesters waiting for the timer
//   rr_ptr   index with highest priority this round
//   winner   first pending index at or after rr_ptr
//   valid    at least one requester pending
module rr_arbiter4 (
    input  logic [3:0] pending,
    input  logic [1:0] rr_ptr,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest pending
    // requester is the last (and therefore winning) assignment.
    always_comb begin
        winner = rr_ptr;
        valid  = 1'b0;
        idx    = '0;
        for (int off = 3; off >= 0; off--) begin
            idx = rr_ptr + 2'(off);
            if (pending[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ostimer_arbiter.sv
// ostimer_arbiter
// Shares one one-shot millisecond timer between NUM_REQ requesters.
// Each requester posts a count; requests are queued as pending bits and
// served round-robin: load the timer, trigger it, wait for its interrupt,
// then report done to the owner.
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    ostimer_arbiter_if.slave (requester and timer signals)
//
// state | meaning
// IDLE  | no timer owner; grant next pending requester if any
// LOAD  | tmr_set high, tmr_value = owner's count
// TRIG  | tmr_trigger high, timer starts
// WAIT  | timer running; tmr_interrupt completes the owner
module ostimer_arbiter #(
    parameter int NUM_REQ = ostimer_arb_pkg::NUM_REQ,
    parameter int VALUE_W = ostimer_arb_pkg::VALUE_W
) (
    input  logic              clk,
    input  logic              reset,
    ostimer_arbiter_if.slave  bus
);
    import ostimer_arb_pkg::*;

    state_t             state;
    logic [NUM_REQ-1:0] pending;
    logic [VALUE_W-1:0] value [NUM_REQ];
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] req_ack;
    logic [NUM_REQ-1:0] done;

    logic [ID_W-1:0]    winner;
    logic               winner_vld;
    logic               expire;
    logic [NUM_REQ-1:0] clr_vec;

    rr_arbiter4 u_rr (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .valid   (winner_vld)
    );

    assign expire = (state == WAIT) && bus.tmr_interrupt;

    always_comb begin
        clr_vec = '0;
        if (expire) begin
            clr_vec[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            req_ack  <= '0;
            done     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                value[i] <= '0;
            end
        end else begin
            // A request landing on the owner's completion cycle is accepted:
            // the new set takes priority over the clear.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i] && (!pending[i] || clr_vec[i])) begin
                    pending[i] <= 1'b1;
                    value[i]   <= bus.req_value[i*VALUE_W +: VALUE_W];
                    req_ack[i] <= 1'b1;
                end else begin
                    pending[i] <= pending[i] & ~clr_vec[i];
                    req_ack[i] <= 1'b0;
                end
            end

            done <= clr_vec;

            case (state)
                IDLE: begin
                    if (winner_vld) begin
                        grant_id <= winner;
                        state    <= LOAD;
                    end
                end
                LOAD: state <= TRIG;
                TRIG: state <= WAIT;
                WAIT: begin
                    if (bus.tmr_interrupt) begin
                        rr_ptr <= next_id(grant_id);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack     = req_ack;
    assign bus.done        = done;
    assign bus.busy        = (state != IDLE);
    assign bus.grant_id    = grant_id;
    assign bus.tmr_set     = (state == LOAD);
    assign bus.tmr_trigger = (state == TRIG);
    assign bus.tmr_value   = (state == LOAD) ? value[grant_id] : '0;

endmodule
